// File: rtl/sw_input_ctrl_pkg.sv
// Shared peripheral definitions for the switch input controller: register map,
// identifier word and debounce defaults.
package sw_input_ctrl_pkg;

    localparam int          DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam logic [31:0] SW_ID                   = 32'h5357_0001;

    typedef enum logic [1:0] {
        REG_STABLE = 2'd0,
        REG_FLAGS  = 2'd1,
        REG_MASK   = 2'd2,
        REG_ID     = 2'd3
    } reg_addr_e;

    // Counter only has to hold DEBOUNCE_CYCLES-1, so clog2 of the cycle count suffices.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-flop synchronizer plus mismatch counter; emits the accepted
// level and a single-cycle pulse on the cycle a change is accepted.
module sw_debounce
    import sw_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable,
    output logic change
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sw;
            sync_q2 <= sync_q1;
        end
    end

    // Combinational so the flag register captures it on the same edge stable flips.
    always_comb begin
        change = (sync_q2 != stable) && (count == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (sync_q2 == stable) begin
            count <= '0;
        end else if (change) begin
            stable <= sync_q2;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sw_input_ctrl.sv
// Debounced switch input peripheral with read-to-clear change flags.
// Define SW_INPUT_IRQ_EN to enable the masked level interrupt.
module sw_input_ctrl
    import sw_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NUM_SW          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_i,
    input  logic              rd_en,
    input  logic [1:0]        rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              irq
);

    logic [NUM_SW-1:0] stable;
    logic [NUM_SW-1:0] change;
    logic [NUM_SW-1:0] flags;
    logic [NUM_SW-1:0] flags_clr;
    logic [NUM_SW-1:0] mask;
    logic [31:0]       rd_mux;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .sw     (sw_i[i]),
            .stable (stable[i]),
            .change (change[i])
        );
    end

    // Clear only the bits being returned; a set arriving on the same edge wins.
    assign flags_clr = (rd_en && (reg_addr_e'(rd_addr) == REG_FLAGS)) ? flags : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~flags_clr) | change;
        end
    end

`ifdef SW_INPUT_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '1;
            irq  <= 1'b0;
        end else begin
            irq  <= |(flags & mask);
        end
    end
`else
    assign mask = '0;
    assign irq  = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_addr_e'(rd_addr))
            REG_STABLE: rd_mux[NUM_SW-1:0] = stable;
            REG_FLAGS:  rd_mux[NUM_SW-1:0] = flags;
            REG_MASK:   rd_mux[NUM_SW-1:0] = mask;
            REG_ID:     rd_mux             = SW_ID;
            default:    rd_mux             = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Scoreboard bench for sw_input_ctrl (DEBOUNCE_CYCLES=4, NUM_SW=16); follows
// SW_INPUT_IRQ_EN if it is defined for the build.
module tb_sw_input_ctrl;

    localparam int DB = 4;
    localparam int NS = 16;
`ifdef SW_INPUT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [NS-1:0] sw_i;
    logic          rd_en;
    logic [1:0]    rd_addr;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          irq;

    sw_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .NUM_SW         (NS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_i     (sw_i),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    logic [31:0] exp_q[$];

    // Reference model state, advanced once per rising edge.
    logic          m_live = 1'b0;
    logic [NS-1:0] m_stable, m_flags, m_raw_d1, m_raw_d2;
    logic [DB-1:0] m_win [NS];
    logic          m_valid, m_irq;
    logic [31:0]   m_data;

    // A level is accepted once the synchronized input (raw input two edges late)
    // has disagreed with the accepted level for DB consecutive edges since reset.
    always @(posedge clk) begin : model
        logic [NS-1:0] mask_m, clr, newf, sync;
        logic [31:0]   rd_exp;
        mask_m = IRQ_EN ? {NS{1'b1}} : '0;
        if (rst) begin
            m_live   = 1'b1;
            m_stable = '0;
            m_flags  = '0;
            m_raw_d1 = '0;
            m_raw_d2 = '0;
            for (int b = 0; b < NS; b++) m_win[b] = '0;
            m_valid  = 1'b0;
            m_irq    = 1'b0;
            m_data   = '0;
        end else begin
            m_irq   = |(m_flags & mask_m);
            m_valid = rd_en;
            clr     = '0;
            if (rd_en) begin
                case (rd_addr)
                    2'd0:    rd_exp = 32'(m_stable);
                    2'd1:    begin rd_exp = 32'(m_flags); clr = m_flags; end
                    2'd2:    rd_exp = 32'(mask_m);
                    default: rd_exp = 32'h5357_0001;
                endcase
                exp_q.push_back(rd_exp);
                m_data = rd_exp;
            end
            sync     = m_raw_d2;
            m_raw_d2 = m_raw_d1;
            m_raw_d1 = sw_i;
            newf     = '0;
            for (int b = 0; b < NS; b++) begin
                m_win[b] = {m_win[b][DB-2:0], sync[b]};
                if (m_win[b] == {DB{~m_stable[b]}}) begin
                    m_stable[b] = ~m_stable[b];
                    newf[b]     = 1'b1;
                end
            end
            m_flags = (m_flags & ~clr) | newf;
        end
    end

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput();
        compare("rd_valid", 32'(rd_valid), 32'(m_valid));
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                compare("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                compare("rd_data", rd_data, exp_q.pop_front());
            end
        end else begin
            compare("rd_hold", rd_data, m_data);
        end
        compare("irq", 32'(irq), 32'(m_irq));
    endtask

    always @(negedge clk) begin
        if (m_live) checkOutput();
    end

    task automatic applyStimulus(input logic [NS-1:0] sw, input logic rd,
                                 input logic [1:0] addr, input logic r);
        @(negedge clk);
        sw_i    = sw;
        rd_en   = rd;
        rd_addr = addr;
        rst     = r;
    endtask

    logic [NS-1:0] cur;

    initial begin
        sw_i    = '0;
        rd_en   = 1'b0;
        rd_addr = 2'd0;
        rst     = 1'b1;
        cur     = '0;
        applyStimulus(cur, 1'b1, 2'd1, 1'b1);
        applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur, 1'b1, 2'd3, 1'b0);

        // Bit 3 rises and is held: poll stable value every cycle across the acceptance.
        cur = 16'h0008;
        for (int i = 0; i < 9; i++) applyStimulus(cur, 1'b1, 2'd0, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b0);

        // Three-cycle glitch on bit 0 must be rejected.
        applyStimulus(cur | 16'h0001, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur | 16'h0001, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur | 16'h0001, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(cur, 1'b1, 2'(i % 2), 1'b0);

        // Bit 5 set, then back-to-back flag reads.
        cur = 16'h0028;
        for (int i = 0; i < 8; i++) applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b0);
        applyStimulus(cur, 1'b0, 2'd0, 1'b0);

        // Bit 3 falls, bit 7 rises two cycles later; flag read lands on bit 7's acceptance edge.
        cur = 16'h0020;
        applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        cur = 16'h00A0;
        for (int i = 0; i < 5; i++) applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b0);
        applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b0);
        applyStimulus(cur, 1'b1, 2'd2, 1'b0);

        // Bit 9 rises; reset lands when its counter is at 2, then the full latency restarts.
        cur = 16'h02A0;
        for (int i = 0; i < 4; i++) applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus(cur, 1'b1, 2'd0, 1'b0);
        applyStimulus(cur, 1'b1, 2'd1, 1'b0);
        applyStimulus(cur, 1'b1, 2'd3, 1'b0);
        applyStimulus(cur, 1'b1, 2'd2, 1'b0);

        // Random switch activity, reads and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) cur[$urandom_range(NS-1)] ^= 1'b1;
            applyStimulus(cur, ($urandom_range(2) == 0), 2'($urandom_range(3)),
                          ($urandom_range(499) == 0));
        end

        for (int i = 0; i < 4; i++) applyStimulus(cur, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        compare("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/sw_input_ctrl.md
SW_INPUT_CTRL -- requirements
Module: sw_input_ctrl

Interface
- REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized cycles required to accept a switch change; legal range 2..65535.
- REQ-002 The block SHALL have parameter NUM_SW, default 16, meaning number of switch inputs; legal range 1..16.
- REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
- REQ-004 Port rst  input  1  reset, synchronous, active-high.
- REQ-005 Port sw_i  input  NUM_SW  raw asynchronous switch levels.
- REQ-006 Port rd_en  input  1  bus read strobe, one cycle per access.
- REQ-007 Port rd_addr  input  2  word register select.
- REQ-008 Port rd_data  output  32  registered read data.
- REQ-009 Port rd_valid  output  1  high exactly one cycle after an accepted rd_en.
- REQ-010 Port irq  output  1  level interrupt, high while any change flag is set and its mask bit is set.

Function
- REQ-011 Each sw_i bit SHALL pass through a 2-flop synchronizer before any other use.
- REQ-012 Per bit, a counter SHALL clear when the synchronized bit equals the stable bit, and increment otherwise.
- REQ-013 When a bit's counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable bit SHALL take the synchronized value on that edge, the counter SHALL clear, and the bit's change flag SHALL set.
- REQ-014 A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) SHALL not change the stable bit or set a flag.
- REQ-015 Counters SHALL saturate logic-wise: a counter never exceeds DEBOUNCE_CYCLES-1, no wrap-around.
- REQ-016 Register map: 0 = stable value (zero-extended), 1 = change flags (read-to-clear), 2 = irq mask (reads back the mask), 3 = constant 32'h5357_0001 identifier.
- REQ-017 Mask register SHALL be loaded from sw-independent port-less default all-ones at reset; it is read-only in this revision.
- REQ-018 Read latency SHALL be one cycle: rd_data/rd_valid update on the edge after rd_en; rd_data holds its last value when rd_en is low.
- REQ-019 A read of address 1 SHALL return the flags sampled before the clear and clear exactly those returned bits.
- REQ-020 If a flag bit is set by debounce on the same edge as a read-clear, the new set SHALL win and the bit SHALL remain 1 afterwards.
- REQ-021 Back-to-back reads on consecutive cycles SHALL each be served; the second flags read returns only bits set since the first.
- REQ-022 Unused upper bits (NUM_SW..31) of registers 0-2 SHALL read 0.

Reset
- REQ-023 On rst high at a clock edge: synchronizers, counters, flags = 0; stable value = 0; rd_data = 0; rd_valid = 0; irq = 0; mask = all ones.
- REQ-024 rst asserted mid-debounce SHALL abandon the count; after release a still-high switch SHALL need the full 2 + DEBOUNCE_CYCLES cycles to appear and SHALL set its flag.
- REQ-025 rd_en during rst SHALL be ignored.

Configuration
- REQ-026 Macro SW_INPUT_IRQ_EN: when defined, irq SHALL be |(flags & mask), registered, one cycle after the flag change; when undefined, irq SHALL be tied 0 and the mask register SHALL read 0.

Structure
- REQ-027 Register offsets, the identifier constant and the default DEBOUNCE_CYCLES SHALL live in the shared peripheral package.
- REQ-028 Per-bit synchronizer plus counter SHALL be a sub-module sw_debounce, instantiated NUM_SW times, outputting stable bit and a one-cycle change pulse.

Verification (DEBOUNCE_CYCLES=4, NUM_SW=16)
- REQ-029 sw_i[3] 0->1 held -> stable bit 3 = 1 and flag 3 set exactly 2+4 cycles after the input edge; read addr 0 returns 32'h0000_0008.
- REQ-030 sw_i[0] pulse of 3 cycles -> stable and flags remain 0; irq stays 0.
- REQ-031 flag 5 set, read addr 1 -> rd_data = 32'h0000_0020, rd_valid one cycle later; immediate second read returns 0.
- REQ-032 flags read coinciding with debounce-set of bit 7 -> returned value excludes bit 7, bit 7 remains set afterwards.
- REQ-033 with SW_INPUT_IRQ_EN defined, any accepted change -> irq 1 next cycle, 0 after flags read; undefined -> irq always 0.
- REQ-034 rst pulse at counter=2 of bit 9 with sw_i[9] held high -> full 6-cycle latency restarts after rst release; addr 3 reads 32'h5357_0001.
